seg_to_hex_capture: RTL and testbench
=====================================

Name: seg_to_hex_capture

Overview:
- Inverse of the board's hex-to-7-segment encoder. Monitors a multiplexed, active-low 7-segment bus: one-hot digit select plus segment pattern.
- Filters out glitches, decodes each stable pattern back to a 4-bit hex nibble, and stores it per digit.
- Used in the chess display path as a loop-back checker and for self-test readback of what the board drives to the HEX displays.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits (1..8).
- STABLE_CYCLES, 3, consecutive identical samples required before commit (>=1).

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- in_SEG  input  7  segment pattern, active-low, bit0=a … bit6=g.
- in_DIGIT  input  NUM_DIGITS  digit select, active-high, expected one-hot or all-zero.
- in_CLR_ERR  input  1  clears out_ERR.
- out_HEX  output  4*NUM_DIGITS  decoded nibbles; digit i occupies bits [4i+3:4i].
- out_VALID  output  NUM_DIGITS  per-digit flag: last commit for that digit decoded to a legal pattern.
- out_UPDATE  output  1  single-cycle pulse on each successful commit.
- out_DIGIT  output  3  index of the most recently committed digit.
- out_ERR  output  1  sticky flag: illegal pattern committed or multi-hot select seen.

Behaviour:
- Clock and reset: one clock domain. Reset is synchronous and active-high.
- Reset values: out_HEX=0, out_VALID=0, out_UPDATE=0, out_DIGIT=0, out_ERR=0. FSM goes to IDLE, the sample register is cleared and the stability counter is 0.
- Reset mid-SETTLE discards the pending pattern; nothing is committed.
- Input stage: {in_DIGIT, in_SEG} is registered every cycle. The FSM acts only on the registered sample.
- Decode table (in_SEG to nibble):
  - 1000000→0, 1111001→1, 0100100→2, 0110000→3
  - 0011001→4, 0010010→5, 0000010→6, 1111000→7
  - 0000000→8, 0011000→9, 0001000→A, 0000011→B
  - 1000110→C, 0100001→D, 0000110→E, 0001110→F
  - Every other pattern is illegal.
- FSM states IDLE, SETTLE, HOLD:
  - IDLE: sample select all-zero → stay. Select one-hot → latch the sample as reference, counter=1, go SETTLE.
  - SETTLE: sample equals reference → counter+1. Sample differs → re-latch the new sample, counter=1, stay SETTLE. If the new select is zero, go IDLE instead.
  - Commit happens on the edge where the counter reaches STABLE_CYCLES, then go HOLD.
  - HOLD: sample unchanged → stay, no re-commit. Sample changed → treat as IDLE entry with the new sample.
- Commit, legal pattern: write the nibble to that digit's slot, set out_VALID[i]=1, out_DIGIT=i, pulse out_UPDATE for one cycle.
- Commit, illegal pattern: slot unchanged, out_VALID[i]=0, out_ERR=1, out_DIGIT=i, no out_UPDATE.
- Latency: for input applied before edge 1 and held, the commit is registered at edge 1+STABLE_CYCLES. Example: STABLE_CYCLES=3 → outputs update at edge 4.
- STABLE_CYCLES=1: commit occurs on the edge after the one-hot sample is first seen (edge 2).
- Multi-hot select in the sample: out_ERR=1 immediately (next edge), FSM goes IDLE, no commit.
- in_CLR_ERR: clears out_ERR on the next edge. If a new error occurs in the same cycle, the error wins (out_ERR stays 1).
- Digit index ≥ NUM_DIGITS is impossible by construction. in_DIGIT is exactly NUM_DIGITS wide.

Optional Feature:
- Macro: SEG_BLANK_EN.
- Defined: pattern 1111111 (all segments off) is legal "blank". Its commit sets out_VALID[i]=0, leaves out_HEX unchanged, does not set out_ERR, and does not pulse out_UPDATE.
- Undefined: 1111111 is an ordinary illegal pattern and sets out_ERR.

Test Plan:
1. Reset, then in_DIGIT=0001, in_SEG=0100100 held 5 cycles (STABLE_CYCLES=3) → at edge 4: out_HEX[3:0]=2, out_VALID=0001, out_UPDATE high exactly one cycle, out_DIGIT=0, out_ERR=0.
2. Glitch filter: in_DIGIT=0010 with in_SEG=0000011 for 2 cycles, then 1000110 for 3 cycles → no commit of B; at the 3rd stable sample +1 edge, out_HEX[7:4]=C, out_VALID[1]=1.
3. Illegal pattern 1010101 on digit 2 held 4 cycles → out_ERR=1, out_VALID[2]=0, out_HEX[11:8] unchanged, no out_UPDATE. Then in_CLR_ERR for 1 cycle → out_ERR=0.
4. Multi-hot in_DIGIT=0011 for 1 cycle → out_ERR=1 on the next edge, no change to out_HEX or out_VALID. Simultaneous in_CLR_ERR in that cycle → out_ERR still 1.
5. Scan all 16 legal patterns across 4 digits, each held 3 cycles, then reset asserted mid-SETTLE → all nibbles match the table, exactly 16 out_UPDATE pulses before reset, and all outputs return to 0 after the reset edge.
6. With SEG_BLANK_EN defined: commit 7 on digit 3, then 1111111 held 3 cycles → out_VALID[3]=0, out_HEX[15:12]=7, out_ERR=0. Without the macro → out_ERR=1.

Source files
------------

// File: rtl/seg_to_hex_capture.sv
// seg_to_hex_capture: watches a multiplexed active-low 7-segment bus and
// recovers the hex nibble shown on each digit. A pattern must hold for
// STABLE_CYCLES registered samples before it is committed.
// Optional feature macro: SEG_BLANK_EN treats 1111111 as a legal "blank"
// that clears the digit's valid flag without raising an error.
module seg_to_hex_capture #(
  parameter int unsigned NUM_DIGITS    = 4,
  parameter int unsigned STABLE_CYCLES = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [6:0]              in_SEG,
  input  logic [NUM_DIGITS-1:0]   in_DIGIT,
  input  logic                    in_CLR_ERR,
  output logic [4*NUM_DIGITS-1:0] out_HEX,
  output logic [NUM_DIGITS-1:0]   out_VALID,
  output logic                    out_UPDATE,
  output logic [2:0]              out_DIGIT,
  output logic                    out_ERR
);

  localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam int unsigned HEX_W = 4 * NUM_DIGITS;

  typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

  // Decode result packed as {legal, blank, nibble}.
  function automatic logic [5:0] decode_seg(input logic [6:0] seg);
    logic [5:0] r;
    r = 6'b000000;
    case (seg)
      7'b1000000: r = {2'b10, 4'h0};
      7'b1111001: r = {2'b10, 4'h1};
      7'b0100100: r = {2'b10, 4'h2};
      7'b0110000: r = {2'b10, 4'h3};
      7'b0011001: r = {2'b10, 4'h4};
      7'b0010010: r = {2'b10, 4'h5};
      7'b0000010: r = {2'b10, 4'h6};
      7'b1111000: r = {2'b10, 4'h7};
      7'b0000000: r = {2'b10, 4'h8};
      7'b0011000: r = {2'b10, 4'h9};
      7'b0001000: r = {2'b10, 4'hA};
      7'b0000011: r = {2'b10, 4'hB};
      7'b1000110: r = {2'b10, 4'hC};
      7'b0100001: r = {2'b10, 4'hD};
      7'b0000110: r = {2'b10, 4'hE};
      7'b0001110: r = {2'b10, 4'hF};
`ifdef SEG_BLANK_EN
      7'b1111111: r = {2'b11, 4'h0};
`endif
      default:    r = 6'b000000;
    endcase
    return r;
  endfunction

  // One-hot select to binary digit index.
  function automatic logic [2:0] digit_index(input logic [NUM_DIGITS-1:0] d);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (d[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  logic [NUM_DIGITS-1:0] dig_q, ref_dig_q, ref_dig_d;
  logic [6:0]            seg_q, ref_seg_q, ref_seg_d;
  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [HEX_W-1:0]      hex_q, hex_d;
  logic [NUM_DIGITS-1:0] valid_q, valid_d;
  logic                  update_q, update_d;
  logic [2:0]            digit_q, digit_d;
  logic                  err_q, err_d;

  logic                  sel_zero, sel_onehot, same, start, commit;
  logic [5:0]            dec;

  // Input sample register, FSM state and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      dig_q     <= '0;
      seg_q     <= '0;
      ref_dig_q <= '0;
      ref_seg_q <= '0;
      state_q   <= IDLE;
      cnt_q     <= '0;
      hex_q     <= '0;
      valid_q   <= '0;
      update_q  <= 1'b0;
      digit_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      dig_q     <= in_DIGIT;
      seg_q     <= in_SEG;
      ref_dig_q <= ref_dig_d;
      ref_seg_q <= ref_seg_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hex_q     <= hex_d;
      valid_q   <= valid_d;
      update_q  <= update_d;
      digit_q   <= digit_d;
      err_q     <= err_d;
    end
  end

  // Next-state, stability counting and commit decode.
  always_comb begin
    state_d   = state_q;
    ref_dig_d = ref_dig_q;
    ref_seg_d = ref_seg_q;
    cnt_d     = cnt_q;
    hex_d     = hex_q;
    valid_d   = valid_q;
    update_d  = 1'b0;
    digit_d   = digit_q;
    err_d     = in_CLR_ERR ? 1'b0 : err_q;
    start     = 1'b0;
    commit    = 1'b0;

    sel_zero   = (dig_q == '0);
    sel_onehot = !sel_zero && ((dig_q & (dig_q - NUM_DIGITS'(1))) == '0);
    same       = (dig_q == ref_dig_q) && (seg_q == ref_seg_q);
    dec        = decode_seg(seg_q);

    if (!sel_zero && !sel_onehot) begin
      // Multi-hot select: flag it and restart; the new error beats a clear.
      err_d   = 1'b1;
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE:   start = 1'b1;
        SETTLE: begin
          if (!same) begin
            start = 1'b1;
          end else if (cnt_q + CNT_W'(1) == CNT_W'(STABLE_CYCLES)) begin
            commit = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        HOLD:    if (!same) start = 1'b1;
        default: state_d = IDLE;
      endcase

      // Fresh sample becomes the reference (or drops back to IDLE on no select).
      if (start) begin
        if (sel_zero) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          ref_dig_d = dig_q;
          ref_seg_d = seg_q;
          cnt_d     = CNT_W'(1);
          if (STABLE_CYCLES == 1) commit = 1'b1;
          else                    state_d = SETTLE;
        end
      end

      // Commit the stable sample into the selected digit's slot.
      if (commit) begin
        state_d = HOLD;
        cnt_d   = '0;
        digit_d = digit_index(dig_q);
        for (int i = 0; i < NUM_DIGITS; i++) begin
          if (dig_q[i]) begin
            if (dec[5] && !dec[4]) begin
              hex_d[4*i +: 4] = dec[3:0];
              valid_d[i]      = 1'b1;
              update_d        = 1'b1;
            end else begin
              valid_d[i] = 1'b0;
              if (!dec[5]) err_d = 1'b1;
            end
          end
        end
      end
    end
  end

  assign out_HEX    = hex_q;
  assign out_VALID  = valid_q;
  assign out_UPDATE = update_q;
  assign out_DIGIT  = digit_q;
  assign out_ERR    = err_q;

endmodule

// File: tb/tb_seg_to_hex_capture.sv
// Directed bench for seg_to_hex_capture (NUM_DIGITS=4, STABLE_CYCLES=3).
// Build with SEG_BLANK_EN defined to exercise the blank-pattern variant.
module tb_seg_to_hex_capture;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  in_SEG;
  logic [3:0]  in_DIGIT;
  logic        in_CLR_ERR;
  logic [15:0] out_HEX;
  logic [3:0]  out_VALID;
  logic        out_UPDATE;
  logic [2:0]  out_DIGIT;
  logic        out_ERR;

  int tests = 0;
  int fails = 0;

  seg_to_hex_capture #(.NUM_DIGITS(4), .STABLE_CYCLES(3)) dut (
    .clk(clk), .reset(reset), .in_SEG(in_SEG), .in_DIGIT(in_DIGIT),
    .in_CLR_ERR(in_CLR_ERR), .out_HEX(out_HEX), .out_VALID(out_VALID),
    .out_UPDATE(out_UPDATE), .out_DIGIT(out_DIGIT), .out_ERR(out_ERR)
  );

  always #5 clk = ~clk;

  // Advance one active edge and settle before looking at outputs.
  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] d, input logic [6:0] s);
    in_DIGIT = d;
    in_SEG   = s;
  endtask

  task automatic test_reset;
    reset = 1'b1; in_CLR_ERR = 1'b0; drive(4'b0000, 7'b1111111);
    step; step;
    tests++; if (out_HEX !== 16'h0000) begin fails++; $display("FAIL reset_hex got %h want 0000", out_HEX); end
    tests++; if (out_VALID !== 4'b0000) begin fails++; $display("FAIL reset_valid got %b want 0000", out_VALID); end
    tests++; if (out_UPDATE !== 1'b0) begin fails++; $display("FAIL reset_update got %b want 0", out_UPDATE); end
    tests++; if (out_DIGIT !== 3'd0) begin fails++; $display("FAIL reset_digit got %0d want 0", out_DIGIT); end
    tests++; if (out_ERR !== 1'b0) begin fails++; $display("FAIL reset_err got %b want 0", out_ERR); end
    reset = 1'b0;
    step;
  endtask

  task automatic test_basic_commit;
    drive(4'b0001, 7'b0100100);
    for (int e = 1; e <= 3; e++) begin
      step;
      tests++; if (out_UPDATE !== 1'b0) begin fails++; $display("FAIL basic_early_update edge %0d got %b want 0", e, out_UPDATE); end
    end
    step; // edge 4
    tests++; if (out_HEX[3:0] !== 4'h2) begin fails++; $display("FAIL basic_hex got %h want 2", out_HEX[3:0]); end
    tests++; if (out_VALID !== 4'b0001) begin fails++; $display("FAIL basic_valid got %b want 0001", out_VALID); end
    tests++; if (out_UPDATE !== 1'b1) begin fails++; $display("FAIL basic_update got %b want 1", out_UPDATE); end
    tests++; if (out_DIGIT !== 3'd0) begin fails++; $display("FAIL basic_digit got %0d want 0", out_DIGIT); end
    tests++; if (out_ERR !== 1'b0) begin fails++; $display("FAIL basic_err got %b want 0", out_ERR); end
    step; // edge 5: pulse must be gone
    tests++; if (out_UPDATE !== 1'b0) begin fails++; $display("FAIL basic_pulse_width got %b want 0", out_UPDATE); end
    drive(4'b0000, 7'b1111111);
    step; step;
  endtask

  task automatic test_glitch_filter;
    drive(4'b0010, 7'b0000011);
    step; step;
    drive(4'b0010, 7'b1000110);
    for (int e = 3; e <= 5; e++) begin
      step;
      tests++; if (out_UPDATE !== 1'b0 || out_HEX[7:4] !== 4'h0) begin
        fails++; $display("FAIL glitch_no_commit edge %0d got upd=%b hex=%h want upd=0 hex=0", e, out_UPDATE, out_HEX[7:4]);
      end
    end
    step; // edge 6
    tests++; if (out_HEX[7:4] !== 4'hC) begin fails++; $display("FAIL glitch_hex got %h want C", out_HEX[7:4]); end
    tests++; if (out_VALID !== 4'b0011) begin fails++; $display("FAIL glitch_valid got %b want 0011", out_VALID); end
    tests++; if (out_UPDATE !== 1'b1 || out_DIGIT !== 3'd1) begin
      fails++; $display("FAIL glitch_update got upd=%b dig=%0d want upd=1 dig=1", out_UPDATE, out_DIGIT);
    end
    drive(4'b0000, 7'b1111111);
    step; step;
  endtask

  task automatic test_illegal;
    drive(4'b0100, 7'b1010101);
    for (int e = 1; e <= 4; e++) begin
      step;
      tests++; if (out_UPDATE !== 1'b0) begin fails++; $display("FAIL illegal_update edge %0d got %b want 0", e, out_UPDATE); end
    end
    tests++; if (out_ERR !== 1'b1) begin fails++; $display("FAIL illegal_err got %b want 1", out_ERR); end
    tests++; if (out_VALID !== 4'b0011) begin fails++; $display("FAIL illegal_valid got %b want 0011", out_VALID); end
    tests++; if (out_HEX !== 16'h00C2) begin fails++; $display("FAIL illegal_hex got %h want 00C2", out_HEX); end
    tests++; if (out_DIGIT !== 3'd2) begin fails++; $display("FAIL illegal_digit got %0d want 2", out_DIGIT); end
    drive(4'b0000, 7'b1111111);
    in_CLR_ERR = 1'b1;
    step;
    in_CLR_ERR = 1'b0;
    tests++; if (out_ERR !== 1'b0) begin fails++; $display("FAIL illegal_clr got %b want 0", out_ERR); end
    step; step;
  endtask

  task automatic test_multihot;
    drive(4'b0011, 7'b1111001);
    step; // sample registered
    tests++; if (out_ERR !== 1'b0) begin fails++; $display("FAIL multihot_early got %b want 0", out_ERR); end
    drive(4'b0000, 7'b1111111);
    in_CLR_ERR = 1'b1;
    step; // FSM sees multi-hot while clear is requested
    in_CLR_ERR = 1'b0;
    tests++; if (out_ERR !== 1'b1) begin fails++; $display("FAIL multihot_err_wins got %b want 1", out_ERR); end
    tests++; if (out_HEX !== 16'h00C2 || out_VALID !== 4'b0011) begin
      fails++; $display("FAIL multihot_state got hex=%h valid=%b want hex=00C2 valid=0011", out_HEX, out_VALID);
    end
    tests++; if (out_UPDATE !== 1'b0) begin fails++; $display("FAIL multihot_update got %b want 0", out_UPDATE); end
    step;
    tests++; if (out_ERR !== 1'b1) begin fails++; $display("FAIL multihot_sticky got %b want 1", out_ERR); end
    in_CLR_ERR = 1'b1;
    step;
    in_CLR_ERR = 1'b0;
    tests++; if (out_ERR !== 1'b0) begin fails++; $display("FAIL multihot_clr got %b want 0", out_ERR); end
    step;
  endtask

  task automatic test_scan_and_reset;
    logic [6:0] pat [16];
    int pulses;
    int late;
    pat[0]  = 7'b1000000; pat[1]  = 7'b1111001; pat[2]  = 7'b0100100; pat[3]  = 7'b0110000;
    pat[4]  = 7'b0011001; pat[5]  = 7'b0010010; pat[6]  = 7'b0000010; pat[7]  = 7'b1111000;
    pat[8]  = 7'b0000000; pat[9]  = 7'b0011000; pat[10] = 7'b0001000; pat[11] = 7'b0000011;
    pat[12] = 7'b1000110; pat[13] = 7'b0100001; pat[14] = 7'b0000110; pat[15] = 7'b0001110;
    pulses = 0;
    for (int k = 0; k < 19; k++) begin
      if (k < 16) drive(4'(1 << (k % 4)), pat[k]);
      else        drive(4'b0000, 7'b1111111);
      for (int j = 0; j < 3; j++) begin
        step;
        if (out_UPDATE === 1'b1) begin
          tests++; if (out_DIGIT !== 3'(pulses % 4) || out_HEX[4*(pulses%4) +: 4] !== 4'(pulses)) begin
            fails++; $display("FAIL scan_commit %0d got dig=%0d nib=%h want dig=%0d nib=%h",
                              pulses, out_DIGIT, out_HEX[4*(pulses%4) +: 4], pulses % 4, 4'(pulses));
          end
          pulses++;
        end
      end
    end
    tests++; if (pulses != 16) begin fails++; $display("FAIL scan_pulses got %0d want 16", pulses); end
    tests++; if (out_HEX !== 16'hFEDC || out_VALID !== 4'b1111) begin
      fails++; $display("FAIL scan_final got hex=%h valid=%b want hex=FEDC valid=1111", out_HEX, out_VALID);
    end
    tests++; if (out_ERR !== 1'b0) begin fails++; $display("FAIL scan_err got %b want 0", out_ERR); end
    // Start a new pattern, then reset while it is still settling.
    drive(4'b0001, 7'b1111001);
    step; step;
    reset = 1'b1;
    drive(4'b0000, 7'b1111111);
    step;
    reset = 1'b0;
    tests++; if (out_HEX !== 16'h0000 || out_VALID !== 4'b0000 || out_UPDATE !== 1'b0 ||
                 out_DIGIT !== 3'd0 || out_ERR !== 1'b0) begin
      fails++; $display("FAIL midsettle_reset got hex=%h valid=%b upd=%b dig=%0d err=%b want all 0",
                        out_HEX, out_VALID, out_UPDATE, out_DIGIT, out_ERR);
    end
    late = 0;
    for (int j = 0; j < 5; j++) begin
      step;
      if (out_UPDATE === 1'b1) late++;
    end
    tests++; if (late != 0 || out_HEX !== 16'h0000 || out_VALID !== 4'b0000) begin
      fails++; $display("FAIL midsettle_discard got upd_count=%0d hex=%h valid=%b want 0 0000 0000", late, out_HEX, out_VALID);
    end
  endtask

  task automatic test_blank;
    int upd;
    logic exp_err;
`ifdef SEG_BLANK_EN
    exp_err = 1'b0;
`else
    exp_err = 1'b1;
`endif
    drive(4'b1000, 7'b1111000);
    step; step; step;
    step; // edge 4
    tests++; if (out_HEX[15:12] !== 4'h7 || out_VALID[3] !== 1'b1 || out_UPDATE !== 1'b1) begin
      fails++; $display("FAIL blank_seed got hex=%h valid3=%b upd=%b want 7 1 1", out_HEX[15:12], out_VALID[3], out_UPDATE);
    end
    drive(4'b1000, 7'b1111111);
    upd = 0;
    for (int j = 0; j < 4; j++) begin
      step;
      if (out_UPDATE === 1'b1) upd++;
    end
    tests++; if (out_VALID[3] !== 1'b0) begin fails++; $display("FAIL blank_valid got %b want 0", out_VALID[3]); end
    tests++; if (out_HEX[15:12] !== 4'h7) begin fails++; $display("FAIL blank_hex got %h want 7", out_HEX[15:12]); end
    tests++; if (out_ERR !== exp_err) begin fails++; $display("FAIL blank_err got %b want %b", out_ERR, exp_err); end
    tests++; if (upd != 0 || out_DIGIT !== 3'd3) begin
      fails++; $display("FAIL blank_update got upd_count=%0d dig=%0d want 0 3", upd, out_DIGIT);
    end
    drive(4'b0000, 7'b1111111);
    step;
  endtask

  initial begin
    test_reset;
    test_basic_commit;
    test_glitch_filter;
    test_illegal;
    test_multihot;
    test_scan_and_reset;
    test_blank;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
